uart_tx_engine: RTL and testbench
=================================

// Module: uart_tx_engine
// PURPOSE
//  Memory-mapped UART transmitter: CPU writes bytes over the uart_sel/uart_wr_enable bus into a FIFO.
//  The block serialises them onto tx_bit as 8N1 frames, LSB first, with a programmable baud divisor.
//  It is the transmit counterpart of the UART receive path and sits on the same peripheral bus.
// PARAMETERS
//  FIFO_DEPTH   4       TX FIFO entries; power of two, >=2
//  DEFAULT_DIV  16'd16  baud divisor after reset (clocks per bit)
// PORTS
//  clock           in   1   system clock, rising edge
//  reset           in   1   asynchronous, active-low reset
//  uart_sel        in   1   peripheral select
//  uart_wr_enable  in   1   write strobe (valid with uart_sel)
//  uart_addr       in   4   register byte address
//  wdata_mem       in   32  write data
//  uart_data       out  32  read data (combinational from uart_addr)
//  tx_bit          out  1   serial output, idle high
//  tx_busy         out  1   high while a frame is on the line or the FIFO is non-empty
// BEHAVIOUR
//  - Reg map. Unmapped addresses read 0; writes to them are ignored.
//    - 0x0 TXDATA: W pushes wdata_mem[7:0]; reads 0.
//    - 0x4 BAUD: R/W [15:0]; a value of 0 is stored as 1.
//    - 0x8 STATUS: R [0] busy, [1] fifo full, [2] overflow (sticky), [3] fifo empty.
//      Writing 1 to bit 2 clears overflow.
//  - Reset (async, reset==0): tx_bit=1, tx_busy=0, FIFO empty, overflow=0, BAUD=DEFAULT_DIV, FSM=IDLE.
//    Reset mid-frame aborts the frame immediately; the line returns high.
//  - Push: occurs on a clock edge with uart_sel & uart_wr_enable & addr==0x0.
//    - If FIFO full: byte dropped, overflow set.
//    - Push and pop in the same cycle on a full FIFO: pop frees the entry, push accepted, no overflow.
//  - FSM states: IDLE -> START -> DATA(8 bits) -> [PARITY] -> STOP -> IDLE.
//    - Back-to-back frames go STOP -> START when the FIFO is non-empty; no idle gap.
//    - IDLE: when FIFO non-empty, pop, latch byte and BAUD, go START on the next edge.
//      tx_bit drives low 1 cycle after the push edge when starting from IDLE with an empty FIFO.
//    - Each bit lasts exactly latched-BAUD clocks; a 16-bit down-counter reloads on each bit boundary.
//    - A BAUD write mid-frame does not affect the current frame; it applies from the next START.
//  - tx_bit and tx_busy are registered outputs.
//  - FIFO pointers are log2(FIFO_DEPTH)+1 bits wide: wrap on the low bits, MSB distinguishes full/empty.
// CONFIGURATION
//  UART_TX_PARITY_EN defined:
//    - Adds a PARITY state after DATA that drives the even-parity bit (^byte) for one bit period.
//    - Frame is 11 bits.
//  UART_TX_PARITY_EN undefined:
//    - PARITY state absent; DATA goes straight to STOP.
//    - Frame is 10 bits.
// STRUCTURE
//  uart_pkg (shared with the receiver):
//    - tx_state_e enum.
//    - Address constants UART_ADDR_TXDATA/BAUD/STATUS.
//    - STATUS bit index constants.
//  Sub-module uart_tx_fifo:
//    - Parameterised sync FIFO (push, pop, wdata, rdata, full, empty), same clock and reset.
// TESTING
//  - Reset with no writes -> tx_bit=1, tx_busy=0, STATUS reads 0x8, BAUD reads 16.
//  - BAUD=4, write 0x55:
//    - tx_bit low 4 clks, then 1,0,1,0,1,0,1,0 each 4 clks, then high 4 clks.
//    - tx_busy deasserts after 40 clks (44 with parity: parity bit 0).
//  - BAUD=2, write 0xA3,0x0F,0xFF back-to-back -> three contiguous frames, no idle gap, bytes in order.
//  - FIFO_DEPTH=4, BAUD=100, write 6 bytes rapidly:
//    - First 5 transmitted (1 in flight + 4 queued), 6th dropped.
//    - STATUS[2]=1; write 0x4 to STATUS clears it.
//  - Write BAUD=8 mid-frame at BAUD=4 -> current frame keeps 4-clk bits; next frame uses 8-clk bits.
//  - Assert reset during DATA bit 3 -> tx_bit high at once, STATUS=0x8, nothing resumes after release.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, register addresses and STATUS bit positions.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  localparam logic [3:0] UART_ADDR_TXDATA = 4'h0;
  localparam logic [3:0] UART_ADDR_BAUD   = 4'h4;
  localparam logic [3:0] UART_ADDR_STATUS = 4'h8;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_OVF   = 2;
  localparam int STAT_EMPTY = 3;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO for the UART transmitter; pointers carry one extra wrap bit
// so full and empty are told apart without a separate counter.
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign rdata = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Storage has no reset so it can map onto plain distributed RAM.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_reg[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_engine.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO and programmable baud divisor.
// Define UART_TX_PARITY_EN to append an even-parity bit (11-bit frames).
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        uart_sel,
  input  logic        uart_wr_enable,
  input  logic [3:0]  uart_addr,
  input  logic [31:0] wdata_mem,
  output logic [31:0] uart_data,
  output logic        tx_bit,
  output logic        tx_busy
);

  tx_state_e   state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [15:0] div_reg, div_next;
  logic [2:0]  bit_reg, bit_next;
  logic [7:0]  byte_reg, byte_next;
  logic        tx_bit_reg, tx_bit_next;
  logic        tx_busy_reg, tx_busy_next;
  logic [15:0] baud_reg;
  logic        ovf_reg;

  logic       wr_hit, push_req, push_ok, pop;
  logic       fifo_full, fifo_empty;
  logic [7:0] fifo_rdata;
  logic       bit_done;
  logic [2:0] bit_inc;
  logic       unused_wdata;

  assign wr_hit       = uart_sel & uart_wr_enable;
  assign push_req     = wr_hit && (uart_addr == UART_ADDR_TXDATA);
  assign push_ok      = push_req && (!fifo_full || pop);
  assign bit_done     = (cnt_reg == 16'd0);
  assign bit_inc      = bit_reg + 3'd1;
  assign unused_wdata = ^wdata_mem[31:16];

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_ok),
    .pop   (pop),
    .wdata (wdata_mem[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      baud_reg <= DEFAULT_DIV;
      ovf_reg  <= 1'b0;
    end else begin
      if (wr_hit && uart_addr == UART_ADDR_BAUD)
        baud_reg <= (wdata_mem[15:0] == 16'd0) ? 16'd1 : wdata_mem[15:0];
      if (push_req && !push_ok)
        ovf_reg <= 1'b1;
      else if (wr_hit && uart_addr == UART_ADDR_STATUS && wdata_mem[STAT_OVF])
        ovf_reg <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= TX_IDLE;
      cnt_reg     <= '0;
      div_reg     <= DEFAULT_DIV;
      bit_reg     <= '0;
      byte_reg    <= '0;
      tx_bit_reg  <= 1'b1;
      tx_busy_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      div_reg     <= div_next;
      bit_reg     <= bit_next;
      byte_reg    <= byte_next;
      tx_bit_reg  <= tx_bit_next;
      tx_busy_reg <= tx_busy_next;
    end
  end

  // tx_bit is computed from the next state so the line changes on the same
  // edge as the state, giving a start bit one cycle after the push edge.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg - 16'd1;
    div_next    = div_reg;
    bit_next    = bit_reg;
    byte_next   = byte_reg;
    tx_bit_next = tx_bit_reg;
    pop         = 1'b0;
    case (state_reg)
      TX_IDLE: begin
        cnt_next    = cnt_reg;
        tx_bit_next = 1'b1;
        if (!fifo_empty) pop = 1'b1;
      end
      TX_START: begin
        if (bit_done) begin
          state_next  = TX_DATA;
          bit_next    = 3'd0;
          cnt_next    = div_reg - 16'd1;
          tx_bit_next = byte_reg[0];
        end
      end
      TX_DATA: begin
        if (bit_done) begin
          cnt_next = div_reg - 16'd1;
          if (bit_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next  = TX_PARITY;
            tx_bit_next = ^byte_reg;
`else
            state_next  = TX_STOP;
            tx_bit_next = 1'b1;
`endif
          end else begin
            bit_next    = bit_inc;
            tx_bit_next = byte_reg[bit_inc];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY: begin
        if (bit_done) begin
          state_next  = TX_STOP;
          cnt_next    = div_reg - 16'd1;
          tx_bit_next = 1'b1;
        end
      end
`endif
      TX_STOP: begin
        if (bit_done) begin
          if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            state_next  = TX_IDLE;
            cnt_next    = 16'd0;
            tx_bit_next = 1'b1;
          end
        end
      end
      default: begin
        state_next  = TX_IDLE;
        cnt_next    = 16'd0;
        tx_bit_next = 1'b1;
      end
    endcase
    // Launching a frame latches BAUD so later writes only affect the next frame.
    if (pop) begin
      state_next  = TX_START;
      byte_next   = fifo_rdata;
      div_next    = baud_reg;
      cnt_next    = baud_reg - 16'd1;
      tx_bit_next = 1'b0;
    end
  end

  assign tx_busy_next = (state_next != TX_IDLE) || !fifo_empty || push_ok;

  always_comb begin
    uart_data = 32'd0;
    case (uart_addr)
      UART_ADDR_BAUD: uart_data = {16'd0, baud_reg};
      UART_ADDR_STATUS: begin
        uart_data[STAT_BUSY]  = tx_busy_reg;
        uart_data[STAT_FULL]  = fifo_full;
        uart_data[STAT_OVF]   = ovf_reg;
        uart_data[STAT_EMPTY] = fifo_empty;
      end
      default: uart_data = 32'd0;
    endcase
  end

  assign tx_bit  = tx_bit_reg;
  assign tx_busy = tx_busy_reg;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: register vectors, directed frame scenarios
// and randomized bursts compared against a frame-level line model.
module tb_uart_tx_engine;

`ifdef UART_TX_PARITY_EN
  localparam int FBITS = 11;
`else
  localparam int FBITS = 10;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        uart_sel = 1'b0;
  logic        uart_wr_enable = 1'b0;
  logic [3:0]  uart_addr = 4'h0;
  logic [31:0] wdata_mem = 32'h0;
  logic [31:0] uart_data;
  logic        tx_bit;
  logic        tx_busy;

  uart_tx_engine #(.FIFO_DEPTH(4), .DEFAULT_DIV(16'd16)) dut (
    .clock          (clock),
    .reset          (reset),
    .uart_sel       (uart_sel),
    .uart_wr_enable (uart_wr_enable),
    .uart_addr      (uart_addr),
    .wdata_mem      (wdata_mem),
    .uart_data      (uart_data),
    .tx_bit         (tx_bit),
    .tx_busy        (tx_busy)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  bit cap_en = 1'b0;
  bit line_q[$];
  bit busy_q[$];
  bit exp_line[$];
  bit exp_busy[$];

  always @(negedge clock) begin
    if (cap_en) begin
      line_q.push_back(tx_bit);
      busy_q.push_back(tx_busy);
    end
  end

  typedef struct packed {
    logic        wr;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = 0x%0h", name, act);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Drive one bus write; the write lands on the next rising edge.
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input bit start_cap);
    uart_sel = 1'b1;
    uart_wr_enable = 1'b1;
    uart_addr = a;
    wdata_mem = d;
    @(posedge clock);
    if (start_cap) begin
      line_q.delete();
      busy_q.delete();
      cap_en = 1'b1;
    end
    #1;
    uart_sel = 1'b0;
    uart_wr_enable = 1'b0;
    uart_addr = 4'h0;
    wdata_mem = 32'h0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    uart_addr = a;
    #1;
    d = uart_data;
  endtask

  // Line model: one idle sample after the first push edge, then the frames
  // concatenated with no gap, each bit held for its frame's divisor, then idle.
  task automatic build_model(input logic [7:0] bytes[$], input int bauds[$], input int total);
    bit fr[$];
    exp_line.delete();
    exp_busy.delete();
    exp_line.push_back(1'b1);
    exp_busy.push_back(1'b1);
    for (int k = 0; k < bytes.size(); k++) begin
      fr.delete();
      fr.push_back(1'b0);
      for (int i = 0; i < 8; i++) fr.push_back(bytes[k][i]);
`ifdef UART_TX_PARITY_EN
      fr.push_back(^bytes[k]);
`endif
      fr.push_back(1'b1);
      foreach (fr[j]) begin
        for (int r = 0; r < bauds[k]; r++) begin
          exp_line.push_back(fr[j]);
          exp_busy.push_back(1'b1);
        end
      end
    end
    while (exp_line.size() < total) begin
      exp_line.push_back(1'b1);
      exp_busy.push_back(1'b0);
    end
  endtask

  task automatic compare_capture(input string name);
    int n = 0;
    int bad_line = -1;
    int bad_busy = -1;
    while (line_q.size() < exp_line.size() && n < exp_line.size() + 100) begin
      @(posedge clock);
      n++;
    end
    #1;
    cap_en = 1'b0;
    tests++;
    if (line_q.size() < exp_line.size()) begin
      fails++;
      $display("FAIL %s capture: got %0d samples expected %0d", name, line_q.size(), exp_line.size());
      return;
    end
    for (int i = 0; i < exp_line.size(); i++) begin
      if (bad_line < 0 && line_q[i] != exp_line[i]) bad_line = i;
      if (bad_busy < 0 && busy_q[i] != exp_busy[i]) bad_busy = i;
    end
    if (bad_line >= 0) begin
      fails++;
      $display("FAIL %s tx_bit: cycle %0d got %0b expected %0b", name, bad_line,
               line_q[bad_line], exp_line[bad_line]);
    end else begin
      $display("[TB] ok %s tx_bit waveform (%0d cycles)", name, exp_line.size());
    end
    tests++;
    if (bad_busy >= 0) begin
      fails++;
      $display("FAIL %s tx_busy: cycle %0d got %0b expected %0b", name, bad_busy,
               busy_q[bad_busy], exp_busy[bad_busy]);
    end else begin
      $display("[TB] ok %s tx_busy waveform", name);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  bytes[$];
    int          bauds[$];
    int          first_low, busy_low, bad;

    // Reset state
    #12;
    check("reset tx_bit", {31'd0, tx_bit}, 32'd1);
    check("reset tx_busy", {31'd0, tx_busy}, 32'd0);
    #1 reset = 1'b1;
    cycles(2);
    check("idle tx_bit", {31'd0, tx_bit}, 32'd1);

    // Register vectors: optional write, then read back
    tbl[0] = '{1'b0, 4'h0, 32'h0,          4'h8, 32'h8};
    tbl[1] = '{1'b0, 4'h0, 32'h0,          4'h4, 32'd16};
    tbl[2] = '{1'b1, 4'h4, 32'h0,          4'h4, 32'd1};
    tbl[3] = '{1'b1, 4'h4, 32'h1234_ABCD,  4'h4, 32'h0000_ABCD};
    tbl[4] = '{1'b1, 4'hC, 32'h5,          4'h4, 32'h0000_ABCD};
    tbl[5] = '{1'b0, 4'h0, 32'h0,          4'hC, 32'h0};
    tbl[6] = '{1'b0, 4'h0, 32'h0,          4'h0, 32'h0};
    tbl[7] = '{1'b1, 4'h5, 32'h7,          4'h4, 32'h0000_ABCD};
    tbl[8] = '{1'b1, 4'h8, 32'hFFFF_FFFF,  4'h8, 32'h8};
    tbl[9] = '{1'b1, 4'h4, 32'd16,         4'h4, 32'd16};
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].wr) bus_write(tbl[i].waddr, tbl[i].wdata, 1'b0);
      bus_read(tbl[i].raddr, rd);
      check($sformatf("vec%0d", i), rd, tbl[i].exp);
    end

    // BAUD=4, single 0x55 frame and busy duration
    bus_write(4'h4, 32'd4, 1'b0);
    bytes = {8'h55};
    bauds = {4};
    build_model(bytes, bauds, 1 + FBITS * 4 + 6);
    bus_write(4'h0, 32'h55, 1'b1);
    compare_capture("frame55");
    first_low = -1;
    busy_low = -1;
    foreach (line_q[i]) if (first_low < 0 && line_q[i] == 1'b0) first_low = i;
    foreach (busy_q[i]) if (busy_low < 0 && first_low >= 0 && i > first_low && busy_q[i] == 1'b0) busy_low = i;
    check("busy clocks 0x55", busy_low - first_low, FBITS * 4);

    // BAUD=2, three back-to-back bytes
    bus_write(4'h4, 32'd2, 1'b0);
    bytes = {8'hA3, 8'h0F, 8'hFF};
    bauds = {2, 2, 2};
    build_model(bytes, bauds, 1 + 3 * FBITS * 2 + 6);
    bus_write(4'h0, 32'hA3, 1'b1);
    bus_write(4'h0, 32'h0F, 1'b0);
    bus_write(4'h0, 32'hFF, 1'b0);
    compare_capture("b2b3");

    // BAUD change mid-frame applies only to the following frame
    bus_write(4'h4, 32'd4, 1'b0);
    bytes = {8'hC6, 8'h39};
    bauds = {4, 8};
    build_model(bytes, bauds, 1 + FBITS * 4 + FBITS * 8 + 6);
    bus_write(4'h0, 32'hC6, 1'b1);
    bus_write(4'h0, 32'h39, 1'b0);
    cycles(10);
    bus_write(4'h4, 32'd8, 1'b0);
    compare_capture("baud_mid");

    // Overflow: 6 rapid writes at BAUD=100, 5 go out
    bus_write(4'h4, 32'd100, 1'b0);
    bytes = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    bauds = {100, 100, 100, 100, 100};
    build_model(bytes, bauds, 1 + 5 * FBITS * 100 + 6);
    bus_write(4'h0, 32'h11, 1'b1);
    for (int i = 2; i <= 6; i++) bus_write(4'h0, 32'h11 * i, 1'b0);
    bus_read(4'h8, rd);
    check("status overflow", rd, 32'h7);
    bus_write(4'h8, 32'h4, 1'b0);
    bus_read(4'h8, rd);
    check("status ovf cleared", rd, 32'h3);
    compare_capture("overflow");

    // Randomized bursts against the line model
    for (int t = 0; t < 6; t++) begin
      int b = $urandom_range(1, 4);
      int n = $urandom_range(1, 3);
      bus_write(4'h4, b, 1'b0);
      bytes.delete();
      bauds.delete();
      for (int k = 0; k < n; k++) begin
        bytes.push_back(8'($urandom_range(0, 255)));
        bauds.push_back(b);
      end
      build_model(bytes, bauds, 1 + n * FBITS * b + 6);
      foreach (bytes[k]) bus_write(4'h0, {24'd0, bytes[k]}, k == 0);
      compare_capture($sformatf("rand%0d baud%0d n%0d", t, b, n));
    end

    // Reset during DATA bit 3 aborts the frame
    bus_write(4'h4, 32'd4, 1'b0);
    bus_write(4'h0, 32'h55, 1'b1);
    cap_en = 1'b0;
    cycles(18);
    check("pre-reset bit3", {31'd0, tx_bit}, 32'd0);
    #1 reset = 1'b0;
    #1;
    check("abort tx_bit", {31'd0, tx_bit}, 32'd1);
    check("abort tx_busy", {31'd0, tx_busy}, 32'd0);
    bus_read(4'h8, rd);
    check("abort status", rd, 32'h8);
    #3 reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (tx_bit !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    check("no resume after reset", bad, 0);
    bus_read(4'h4, rd);
    check("baud after reset", rd, 32'd16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
